modm_counter_ud: RTL and testbench
==================================

# modm_counter_ud

Parameterised modulo-m up/down counter with runtime-programmable terminal value, synchronous clear, parallel load, count enable and cascade carry. It generalises the fixed-modulus counter used across the design, and serves as the standard tick and divide-by-m source for timers, baud generators and display scanners. Chained instances are cascaded by feeding one stage's `carry` into the next stage's `en`.

## Interface
- `M_MAX`, default 10: largest supported modulus; the counter range is 0..M_MAX-1.
- `N`, default $clog2(M_MAX): width of the count and data ports; must be ≥1.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clr`  in  1: synchronous clear to 0; also clears `ovf`.
- `load`  in  1: synchronous parallel load of `d`.
- `d`  in  N: load value.
- `en`  in  1: count enable, one step per enabled cycle.
- `up`  in  1: direction; 1 counts up, 0 counts down.
- `last`  in  N: runtime terminal value; effective modulus is `last`+1.
- `q`  out  N: registered count.
- `term`  out  1: combinational; `q` equals the terminal value for the current direction.
- `carry`  out  1: combinational; `en & term & ~clr & ~load`, meaning a wrap happens at this edge.
- `ovf`  out  1: registered sticky flag; set on any wrap, cleared by `rst` or `clr`.

## Operation
- Effective terminal `lim` = min(`last`, M_MAX-1). `last` values ≥ M_MAX are clamped; they are not an error.
- Terminal value is `lim` when `up`=1 and 0 when `up`=0. `term` is asserted when `q` equals that value. When `up`=1 it is also asserted if `q` > `lim` (see below).
- Priority per rising edge, highest first: `rst` > `clr` > `load` > `en` > hold.
- `clr`: `q`←0, `ovf`←0.
- `load`: `q`←min(`d`, `lim`). `ovf` is unchanged. No carry is generated.
- `en`, `up`=1: if `q` ≥ `lim`, then `q`←0 and `ovf`←1. Otherwise `q`←`q`+1.
- `en`, `up`=0: if `q`=0, then `q`←`lim` and `ovf`←1. If `q` > `lim`, then `q`←`lim` with no wrap. Otherwise `q`←`q`-1.
- `en`=0: `q` and `ovf` hold.
- `last`=0 gives a modulus of 1. `q` stays 0 and every enabled cycle is a wrap, so `carry`=`en`.
- `last` may change on any cycle. Out-of-range `q` is corrected only by the next enabled step or by a load; it is never corrected silently while idle.
- Direction may change on any cycle. The step uses the `up` value sampled at that edge.
- All arithmetic is N-bit. The increment is computed in N+1 bits so that the compare never aliases when M_MAX = 2^N.

## Timing
- Reset values: `q`=0 and `ovf`=0. With `up`=1 and `last`>0, `term`=0 and `carry`=0. With `up`=0, `term`=1 at reset.
- `rst` acts immediately, without waiting for a clock. It may be asserted mid-count. Counting resumes at the first rising edge after `rst` deasserts, starting from 0.
- `q` and `ovf` update one cycle after the controlling inputs are sampled. There is no pipeline.
- `term` and `carry` are combinational from `q`, `up`, `last`, `en`, `clr` and `load`. They are valid in the same cycle as the wrap edge they predict.
- Up-count period: with `en` held at 1, `carry` pulses for one cycle every `lim`+1 cycles.
- Cascade: stage k+1 `en` = stage k `carry`. A chain of stages advances all stages on the same edge, with no added latency.

## Test plan
- Reset and idle: assert `rst` asynchronously mid-cycle with `q`=7 -> `q`=0 and `ovf`=0 before the next edge, and both hold while `rst` stays high.
- Up wrap: M_MAX=10, `last`=9, `up`=1, `en`=1 for 25 cycles from 0 -> `q` runs 0..9,0..9,0..4. `carry` is high in the cycles with `q`=9 (cycles 10 and 20). `ovf` is 1 after the first wrap.
- Down wrap with runtime modulus: `last`=5, `up`=0, `en`=1 from 0 -> `q` runs 0,5,4,3,2,1,0,5. `carry` is high whenever `q`=0.
- Clamp and out-of-range: load `d`=12 with M_MAX=10 -> `q`=9. With `q`=8, set `last`=3 and count up -> `q`=0 and `ovf` is set. With `q`=8, set `last`=3 and count down -> `q`=3 and `ovf` is unchanged.
- Priority: with `clr`, `load`=1, `d`=4 and `en` all high on the same edge -> `q`=0 and `ovf`=0. With `load` and `en` only, `d`=4 -> `q`=4 and `carry`=0.
- Cascade: two instances with `last`=9, where the low stage's `carry` drives the high stage's `en`, clocked for 100 enabled cycles -> counts {high,low} 00..99 and then wraps to 00. The high stage's `carry` fires only in the cycle where the chain shows 99.

Source files
------------

// File: rtl/modm_counter_ud.sv
// Modulo-m up/down counter with a runtime terminal value, synchronous clear,
// parallel load, count enable and a cascade carry for chaining stages.
module modm_counter_ud #(
  parameter int M_MAX = 10,
  parameter int N     = (M_MAX > 1) ? $clog2(M_MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] last,
  output logic [N-1:0] q,
  output logic         term,
  output logic         carry,
  output logic         ovf
);

  localparam logic [N-1:0] LIM_MAX = N'(M_MAX - 1);

  function automatic logic [N-1:0] clamp_to(input logic [N-1:0] val,
                                             input logic [N-1:0] ceil);
    return (val > ceil) ? ceil : val;
  endfunction

  logic [N-1:0] q_r;
  logic         ovf_r;
  logic [N-1:0] lim_s;
  logic [N:0]   inc_s;
  logic         wrap_up_s;
  logic         term_s;
  logic         carry_s;
  logic [N-1:0] q_nxt_s;
  logic         ovf_nxt_s;

  // Effective terminal, increment and wrap prediction.
  // The increment carries an extra bit so q = 2^N-1 never aliases to 0 in the compare.
  always_comb begin
    lim_s     = clamp_to(last, LIM_MAX);
    inc_s     = {1'b0, q_r} + {{N{1'b0}}, 1'b1};
    wrap_up_s = (inc_s > {1'b0, lim_s});
    term_s    = up ? wrap_up_s : (q_r == {N{1'b0}});
    carry_s   = en & term_s & ~clr & ~load;
  end

  // Next-state selection in priority order: clear, load, count, hold.
  always_comb begin
    q_nxt_s   = q_r;
    ovf_nxt_s = ovf_r;
    if (clr) begin
      q_nxt_s   = {N{1'b0}};
      ovf_nxt_s = 1'b0;
    end else if (load) begin
      q_nxt_s   = clamp_to(d, lim_s);
      ovf_nxt_s = ovf_r;
    end else if (en) begin
      if (up) begin
        if (wrap_up_s) begin
          q_nxt_s   = {N{1'b0}};
          ovf_nxt_s = 1'b1;
        end else begin
          q_nxt_s   = inc_s[N-1:0];
          ovf_nxt_s = ovf_r;
        end
      end else begin
        if (q_r == {N{1'b0}}) begin
          q_nxt_s   = lim_s;
          ovf_nxt_s = 1'b1;
        end else if (q_r > lim_s) begin
          // out-of-range count snaps back to the terminal without a wrap
          q_nxt_s   = lim_s;
          ovf_nxt_s = ovf_r;
        end else begin
          q_nxt_s   = q_r - {{N{1'b0}}, 1'b1};
          ovf_nxt_s = ovf_r;
        end
      end
    end else begin
      q_nxt_s   = q_r;
      ovf_nxt_s = ovf_r;
    end
  end

  // Count and sticky wrap flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= {N{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign q     = q_r;
  assign ovf   = ovf_r;
  assign term  = term_s;
  assign carry = carry_s;

endmodule

// File: tb/tb_modm_counter_ud.sv
// Scoreboard bench for modm_counter_ud: a driver pushes expectations from an
// arithmetic reference model, monitors pop and compare on the falling edge.
module tb_modm_counter_ud;

  localparam int M = 10;

  logic       clk;
  logic       rst, clr, load, en, up;
  logic [3:0] d, last;
  logic [3:0] q;
  logic       term, carry, ovf;

  logic       casc_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_term, hi_term, lo_carry, hi_carry, lo_ovf, hi_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] q;
    logic       ovf;
    logic       term;
    logic       carry;
  } exp_t;

  typedef struct {
    int v;
    bit hc;
    bit lc;
  } casc_t;

  exp_t  sb_q[$];
  casc_t cb_q[$];

  int mq;
  bit movf;

  modm_counter_ud #(.M_MAX(M)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .last(last), .q(q), .term(term), .carry(carry), .ovf(ovf)
  );

  modm_counter_ud #(.M_MAX(M)) u_lo (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .d(4'd0), .en(casc_en),
    .up(1'b1), .last(4'd9), .q(lo_q), .term(lo_term), .carry(lo_carry), .ovf(lo_ovf)
  );

  modm_counter_ud #(.M_MAX(M)) u_hi (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .d(4'd0), .en(lo_carry),
    .up(1'b1), .last(4'd9), .q(hi_q), .term(hi_term), .carry(hi_carry), .ovf(hi_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (called at posedge+1), queue the expected
  // outputs for this cycle, then advance the reference model.
  task automatic step(input logic c, input logic l, input logic [3:0] dv,
                      input logic e, input logic u_i, input logic [3:0] lv);
    int   lim;
    int   nq;
    exp_t x;
    clr = c; load = l; d = dv; en = e; up = u_i; last = lv;
    lim = (int'(lv) < M - 1) ? int'(lv) : M - 1;
    x.q     = 4'(mq);
    x.ovf   = movf;
    x.term  = u_i ? (mq >= lim) : (mq == 0);
    x.carry = e & x.term & ~c & ~l;
    sb_q.push_back(x);
    if (c) begin
      mq = 0; movf = 0;
    end else if (l) begin
      mq = (int'(dv) < lim) ? int'(dv) : lim;
    end else if (e) begin
      if (mq > lim) begin
        if (u_i) begin mq = 0; movf = 1; end
        else mq = lim;
      end else if (u_i) begin
        nq = (mq + 1) % (lim + 1);
        if (nq == 0) movf = 1;
        mq = nq;
      end else begin
        if (mq == 0) movf = 1;
        mq = (mq + lim) % (lim + 1);
      end
    end
    @(posedge clk); #1;
  endtask

  // Main-counter monitor.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        chk("q",     int'(q),     int'(x.q));
        chk("ovf",   int'(ovf),   int'(x.ovf));
        chk("term",  int'(term),  int'(x.term));
        chk("carry", int'(carry), int'(x.carry));
      end
    end
  end

  // Cascade monitor.
  initial begin
    casc_t x;
    forever begin
      @(negedge clk);
      if (cb_q.size() != 0) begin
        x = cb_q.pop_front();
        chk("casc_hi",       int'(hi_q),     x.v / 10);
        chk("casc_lo",       int'(lo_q),     x.v % 10);
        chk("casc_hi_carry", int'(hi_carry), int'(x.hc));
        chk("casc_lo_carry", int'(lo_carry), int'(x.lc));
      end
    end
  end

  initial begin
    logic       u;
    logic [3:0] lv;
    casc_t      cx;
    rst = 1'b1; clr = 1'b0; load = 1'b0; d = 4'd0; en = 1'b0; up = 1'b0;
    last = 4'd9; casc_en = 1'b0;
    mq = 0; movf = 0;
    #2;
    chk("rst_q",      int'(q),     0);
    chk("rst_ovf",    int'(ovf),   0);
    chk("rst_term_dn", int'(term), 1);
    up = 1'b1;
    #1;
    chk("rst_term_up",  int'(term),  0);
    chk("rst_carry_up", int'(carry), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Up wrap over 25 cycles.
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
    // Down wrap with a runtime modulus of 6.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5);
    // Priority: clear beats load and enable; load suppresses carry.
    step(1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 4'd9);
    step(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd9);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);
    // Clamp of load value, then out-of-range count up and down.
    step(1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 4'd9);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 4'd9);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 4'd9);
    step(1'b0, 1'b0, 4'd0, 0, 1'b0, 4'd3);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3);
    // Modulus 1: every enabled cycle is a wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b1, i[0], 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0);

    // Randomised run.
    u = 1'b1; lv = 4'd9;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)  u = ~u;
      if ($urandom_range(0, 19) == 0) lv = 4'($urandom_range(0, 15));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, u, lv);
    end

    // Asynchronous reset mid-cycle with q = 7 and ovf set.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd9);
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd9);
    load = 1'b0; en = 1'b0;
    #3;
    chk("pre_rst_q",   int'(q),   7);
    chk("pre_rst_ovf", int'(ovf), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_q",   int'(q),   0);
    chk("async_rst_ovf", int'(ovf), 0);
    en = 1'b1;
    @(posedge clk); #1;
    chk("hold_rst_q",   int'(q),   0);
    chk("hold_rst_ovf", int'(ovf), 0);
    en = 1'b0;
    @(negedge clk); rst = 1'b0;
    mq = 0; movf = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9);

    // Two-stage decimal cascade over 100 enabled cycles.
    for (int i = 0; i < 100; i++) begin
      casc_en = 1'b1;
      cx.v = i; cx.hc = (i == 99); cx.lc = ((i % 10) == 9);
      cb_q.push_back(cx);
      @(posedge clk); #1;
    end
    casc_en = 1'b0;
    cx.v = 0; cx.hc = 1'b0; cx.lc = 1'b0;
    cb_q.push_back(cx);
    @(posedge clk); #1;

    @(negedge clk); @(negedge clk); #1;
    chk("sb_drain",   sb_q.size(), 0);
    chk("casc_drain", cb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
